pr_bus_arbiter: RTL and testbench
=================================

# pr_bus_arbiter

Round-robin arbiter that shares the 4-bit `pr_bus` output among four requesters. It registers a one-hot grant and the matching encoded select, and steers the owner's data onto `bus_out`. A one-cycle turnaround gap separates consecutive owners so two drivers never overlap. It sits between the requesting units and the bus driver; `sel` feeds the bus select input directly.

## Interface
- `DW`, default 4: bus and per-requester data width.
- `MAX_HOLD`, default 8: maximum number of consecutive cycles an owner keeps the bus while another requester is waiting; legal range 1..15.
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  4: request per requester; level-sensitive, held until the requester is done.
- `data_in`  in  4*DW: requester i data on bits [i*DW +: DW].
- `gnt`  out  4: registered one-hot grant; all zero when nobody owns the bus.
- `sel`  out  2: registered binary index of the current or last owner.
- `bus_out`  out  DW: `data_in` slice of the owner while `bus_valid` is high, otherwise 0.
- `bus_valid`  out  1: high exactly while the state is OWN.
- `busy`  out  1: high in OWN and GAP.

## Operation
- FSM states: IDLE, OWN, GAP. All state is registered.
- Round-robin pointer `last` (2 bits) holds the index of the most recent grant. The search order is `last+1`, `last+2`, `last+3`, `last` (mod 4). The first requester in that order with `req` high wins.
- IDLE: if any `req` bit is high, go to OWN with the winner. `gnt` is set to the winner, `sel` is set to its index, `last` is updated to it, and `hold_cnt` is cleared to 0.
- OWN: `hold_cnt` increments each cycle and saturates at `MAX_HOLD-1`. `others` means any `req` bit other than the owner's.
  - Go to GAP if `req[sel]` is 0 (release).
  - Go to GAP if `hold_cnt == MAX_HOLD-1` and `others` is high (preemption).
  - Otherwise stay in OWN. With no competitor, ownership is unlimited.
- GAP: lasts exactly one cycle, with `gnt` = 0 and `bus_valid` = 0. On exit, arbitrate like IDLE using the current `req`. Go to OWN if any request is pending, otherwise go to IDLE.
- A preempted owner that still holds `req` is re-queued by round-robin order. It is not re-granted ahead of the others, because `last` points at it.
- `sel` holds its last value in IDLE and GAP; only `gnt` and `bus_valid` are cleared.
- `bus_out` is a combinational mux of `data_in[sel]`, gated by `bus_valid`.
- Reset, asynchronous and immediate: state IDLE, `gnt` 0000, `sel` 00, `last` 3 (so requester 0 wins first), `hold_cnt` 0, `bus_valid` 0, `busy` 0, `bus_out` 0.
- Reset asserted mid-ownership drops `gnt` in the same instant. There is no GAP cycle after reset is released.

## Timing
- Request to grant from IDLE: `req` is high before edge N, so `gnt` and `bus_valid` are high after edge N. Latency is 1 cycle.
- Release: `req[owner]` falls before edge N, so `gnt` is 0 after edge N (GAP). The next grant appears after edge N+1. Minimum owner-to-owner distance is 1 idle bus cycle.
- Preemption: with a competitor waiting, the owner has `bus_valid` high for exactly `MAX_HOLD` cycles. It is then followed by 1 GAP cycle and the next grant.
- `MAX_HOLD` = 1: the owner gets 1 cycle, then GAP, whenever there is contention.
- Owner drops `req` on the same edge that the hold limit is reached: treated as a release. Same GAP and same pointer behaviour.
- All four requests asserted together out of reset: grants go in order 0, 1, 2, 3, 0, and so on.
- `data_in` changes propagate to `bus_out` combinationally while in OWN. There is no added latency.

## Test plan
- Reset with `req`=1111: `gnt`=0000, `sel`=0, `bus_out`=0. After `rst_n` rises, the next edge gives `gnt`=0001 and `sel`=0.
- Single requester: `req`=0100 with `data_in[11:8]`=A, held 20 cycles. Required: `gnt`=0100, `bus_out`=A, and `bus_valid` high continuously for all 20 cycles with no preemption. Drop `req`: GAP, then IDLE.
- Release handoff: owner 0 holds 3 cycles then drops, while `req[2]` is held. Required: 3 OWN cycles for 0, 1 GAP cycle, then `gnt`=0100 and `sel`=2.
- Preemption with `MAX_HOLD`=8 and `req`=1001 held constantly: owner 0 is valid 8 cycles, GAP, owner 3 for 8 cycles, GAP, owner 0 again.
- Round-robin fairness: `req`=1111 held, each owner releasing after 2 cycles and re-requesting immediately. Grant sequence is 0, 1, 2, 3, 0, 1, with exactly 1 GAP between each.
- Mid-ownership reset: `rst_n` pulled low during owner 1's third cycle. Outputs go to 0 asynchronously. After release, with `req`=0010, requester 1 is granted 1 edge later.

Source files
------------

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: four-way round-robin owner of a shared DW-bit bus.
// Grants are registered and one-hot, with a matching binary select.
// A one-cycle GAP always separates two owners so their drivers never overlap.
// Request/grant contract: a requester holds req high, level-sensitive, until
// it is done. It owns the bus for every cycle in which its gnt bit is high.
// Dropping req releases the bus at the next edge. It may be preempted after
// MAX_HOLD owned cycles if someone else is waiting.
module pr_bus_arbiter #(
    parameter int DW       = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] data_in,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic [DW-1:0]   bus_out,
    output logic            bus_valid,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Saturation point of the hold counter; reaching it with a competitor waiting ends ownership.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] last_q, last_d;
    logic [3:0] hold_q, hold_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       others;

    // Round-robin search: nearest requester after last wins, last itself is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // A competitor is any requester other than the current owner.
    assign others = |(req & ~gnt_q);

    // Next-state logic: arbitrate from IDLE/GAP, release or preempt from OWN.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE, S_GAP: begin
                gnt_d = 4'b0000;
                if (win_found) begin
                    state_d = S_OWN;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    hold_d  = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OWN: begin
                if (!req[sel_q] || ((hold_q == HOLD_LAST) && others)) begin
                    state_d = S_GAP;
                    gnt_d   = 4'b0000;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State register; reset leaves the pointer at 3 so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign bus_valid = (state_q == S_OWN);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    // Owner's data steered straight through, forced to zero whenever nobody owns the bus.
    always_comb begin
        bus_out = '0;
        if (bus_valid) begin
            bus_out = data_in[sel_q*DW +: DW];
        end
    end

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed bench for pr_bus_arbiter with DW=4, MAX_HOLD=8.
// Each step pushes the expected {gnt, sel, bus_valid, busy, bus_out} and
// pops it one edge later.
module tb_pr_bus_arbiter;

    localparam int DW = 4;
    localparam int EW = 4 + 2 + 1 + 1 + DW;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req;
    logic [4*DW-1:0] data_in;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic [DW-1:0]   bus_out;
    logic            bus_valid;
    logic            busy;
    logic [1:0]      dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs;
    logic [1:0]    es;
    int            total;
    int            bad;

    pr_bus_arbiter #(.DW(DW), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .sel       (sel),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign obs = {gnt, sel, bus_valid, busy, bus_out};

    function automatic logic [EW-1:0] mk(input logic [3:0] g, input logic [1:0] s,
                                         input logic v, input logic b);
        logic [DW-1:0] d;
        d = v ? data_in[s*DW +: DW] : '0;
        return {g, s, v, b, d};
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] o, input logic [EW-1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // driver: apply req, expect the given outputs after the next rising edge
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input logic b, input string tag);
        req = r;
        exp_q.push_back(mk(g, s, v, b));
        @(posedge clk);
        #1;
        chk(tag, obs, exp_q.pop_front());
    endtask

    task automatic own_run(input logic [3:0] r, input logic [1:0] k, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(r, 4'b0001 << k, k, 1'b1, 1'b1, tag);
        end
        es = k;
    endtask

    task automatic gap_step(input logic [3:0] r, input string tag);
        step(r, 4'b0000, es, 1'b0, 1'b1, tag);
    endtask

    task automatic idle_step(input logic [3:0] r, input string tag);
        step(r, 4'b0000, es, 1'b0, 1'b0, tag);
    endtask

    // reset pulse between edges; outputs must clear without waiting for a clock
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        es = 2'd0;
        chk(tag, obs, mk(4'b0000, 2'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        es      = 2'd0;
        rst_n   = 1'b0;
        req     = 4'b1111;
        data_in = 16'h9536;

        // reset with all requests high, then 0,1,2,3,0 under preemption
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", obs, mk(4'b0000, 2'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        own_run(4'b1111, 2'd0, 8, "all4_own0");
        gap_step(4'b1111, "all4_gap0");
        own_run(4'b1111, 2'd1, 8, "all4_own1");
        gap_step(4'b1111, "all4_gap1");
        own_run(4'b1111, 2'd2, 8, "all4_own2");
        gap_step(4'b1111, "all4_gap2");
        own_run(4'b1111, 2'd3, 8, "all4_own3");
        gap_step(4'b1111, "all4_gap3");
        own_run(4'b1111, 2'd0, 1, "all4_own0b");

        // single requester 2 owns 20 cycles without preemption
        gap_step(4'b0100, "single_gap_in");
        own_run(4'b0100, 2'd2, 20, "single_own2");
        data_in[11:8] = 4'hE;
        #1;
        chk("comb_data", obs, mk(4'b0100, 2'd2, 1'b1, 1'b1));
        gap_step(4'b0000, "single_gap");
        idle_step(4'b0000, "single_idle");

        // release handoff: owner 0 for 3 cycles, then requester 2
        own_run(4'b0101, 2'd0, 3, "handoff_own0");
        gap_step(4'b0100, "handoff_gap");
        own_run(4'b0100, 2'd2, 1, "handoff_own2");
        gap_step(4'b0000, "handoff_gap_end");
        idle_step(4'b0000, "handoff_idle");

        // reset during owner 1's third cycle, then a 1-edge regrant
        own_run(4'b0010, 2'd1, 3, "midrst_own1");
        pulse_reset("midrst_async");
        own_run(4'b0010, 2'd1, 1, "midrst_regrant");
        gap_step(4'b0000, "midrst_gap");
        idle_step(4'b0000, "midrst_idle");

        // preemption with req=1001 held
        pulse_reset("rst_before_preempt");
        own_run(4'b1001, 2'd0, 8, "pre_own0");
        gap_step(4'b1001, "pre_gap0");
        own_run(4'b1001, 2'd3, 8, "pre_own3");
        gap_step(4'b1001, "pre_gap3");
        own_run(4'b1001, 2'd0, 8, "pre_own0b");
        // owner drops req on the same edge the hold limit is reached
        gap_step(4'b1000, "limit_release_gap");
        own_run(4'b1000, 2'd3, 1, "limit_release_own3");
        gap_step(4'b0000, "limit_gap_end");
        idle_step(4'b0000, "limit_idle");

        // fairness: each owner releases after 2 cycles and re-requests at once
        pulse_reset("rst_before_fair");
        own_run(4'b1111, 2'd0, 2, "fair_own0");
        gap_step(4'b1110, "fair_gap0");
        own_run(4'b1111, 2'd1, 2, "fair_own1");
        gap_step(4'b1101, "fair_gap1");
        own_run(4'b1111, 2'd2, 2, "fair_own2");
        gap_step(4'b1011, "fair_gap2");
        own_run(4'b1111, 2'd3, 2, "fair_own3");
        gap_step(4'b0111, "fair_gap3");
        own_run(4'b1111, 2'd0, 2, "fair_own0b");
        gap_step(4'b1110, "fair_gap0b");
        own_run(4'b1111, 2'd1, 2, "fair_own1b");
        gap_step(4'b1101, "fair_gap1b");
        idle_step(4'b0000, "fair_idle");

        total++;
        assert (exp_q.size() === 0) else begin
            bad++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
